// File: rtl/hansen_mem_responder.sv
// Memory-side responder for the Hansen core: word RAM with registered read,
// one debug MMIO register, and a byte-serial loader that holds the core in reset.
module hansen_mem_responder #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    output logic [31:0] mem_rdata,
    output logic        core_hold,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    output logic        load_done,
    output logic [31:0] dbg_data,
    output logic        dbg_valid
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [31:0]            asm_q, asm_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            dbg_data_q, dbg_data_d;
    logic                   dbg_valid_q, dbg_valid_d;

    logic [31:0]            ram [DEPTH];

    logic [31:0]            word_s;
    logic                   ram_we_s;
    logic [ADDR_BITS-1:0]   ram_waddr_s;
    logic [31:0]            ram_wdata_s;
    logic [ADDR_BITS-1:0]   idx_s;
    logic                   in_range_s;
    logic                   mmio_hit_s;
    logic                   unused_addr_s;

    assign idx_s         = mem_addr[ADDR_BITS+1:2];
    assign in_range_s    = (mem_addr[31:ADDR_BITS+2] == '0);
    assign mmio_hit_s    = (mem_addr[31:2] == MMIO_ADDR[31:2]);
    assign unused_addr_s = &{1'b0, mem_addr[1:0]};

    // Merge the incoming byte into its lane; upper lanes are still zero.
    always_comb begin
        word_s = asm_q;
        word_s[{byte_cnt_q, 3'b000} +: 8] = load_byte;
    end

    // Next-state, loader sequencing, RAM write port selection and read mux.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        ptr_d       = ptr_q;
        asm_d       = asm_q;
        rdata_d     = 32'h0000_0000;
        dbg_data_d  = dbg_data_q;
        dbg_valid_d = 1'b0;
        ram_we_s    = 1'b0;
        ram_waddr_s = ptr_q;
        ram_wdata_s = word_s;
        case (state_q)
            S_LOAD: begin
                if (load_valid) begin
                    if ((byte_cnt_q == 2'd3) || load_last) begin
                        ram_we_s   = 1'b1;
                        ptr_d      = ptr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                        asm_d      = 32'h0000_0000;
                        byte_cnt_d = 2'd0;
                        // A full RAM ends the load just like an explicit last byte.
                        if (load_last || (&ptr_q)) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        asm_d      = word_s;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                if (in_range_s) begin
                    rdata_d = ram[idx_s];
                end else if (mmio_hit_s) begin
                    rdata_d = dbg_data_q;
                end else begin
                    rdata_d = 32'h0000_0000;
                end
                if (mem_we && in_range_s) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = idx_s;
                    ram_wdata_s = mem_wdata;
                end else if (mem_we && mmio_hit_s) begin
                    dbg_data_d  = mem_wdata;
                    dbg_valid_d = 1'b1;
                end else begin
                    ram_we_s = 1'b0;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOAD;
            byte_cnt_q  <= 2'd0;
            ptr_q       <= '0;
            asm_q       <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            dbg_data_q  <= 32'h0000_0000;
            dbg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            ptr_q       <= ptr_d;
            asm_q       <= asm_d;
            rdata_q     <= rdata_d;
            dbg_data_q  <= dbg_data_d;
            dbg_valid_q <= dbg_valid_d;
        end
    end

    // RAM array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s && !reset) begin
            ram[ram_waddr_s] <= ram_wdata_s;
        end
    end

    assign mem_rdata  = rdata_q;
    assign core_hold  = (state_q == S_LOAD);
    assign load_ready = (state_q == S_LOAD);
    assign load_done  = (state_q == S_RUN);
    assign dbg_data   = dbg_data_q;
    assign dbg_valid  = dbg_valid_q;

endmodule

// File: tb/tb_hansen_mem_responder.sv
// Directed bench for hansen_mem_responder: loader, RUN reads/writes, MMIO and resets.
module tb_hansen_mem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        core_hold;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_done;
    logic [31:0] dbg_data;
    logic        dbg_valid;

    int vectors = 0;
    int errors  = 0;

    localparam logic [31:0] MMIO = 32'hFFFF_FFF0;

    hansen_mem_responder #(.ADDR_BITS(10), .MMIO_ADDR(MMIO)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .core_hold  (core_hold),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .load_done  (load_done),
        .dbg_data   (dbg_data),
        .dbg_valid  (dbg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        @(negedge clk);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        @(negedge clk);
        mem_addr = a;
        mem_we   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_addr = 32'h0; mem_wdata = 32'h0; mem_we = 1'b0;
        load_valid = 1'b0; load_byte = 8'h00; load_last = 1'b0;
        #12;
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_core_hold", {31'h0, core_hold}, 32'h1);
        check("rst_load_ready", {31'h0, load_ready}, 32'h1);
        check("rst_load_done", {31'h0, load_done}, 32'h0);
        check("rst_dbg_data", dbg_data, 32'h0);
        check("rst_dbg_valid", {31'h0, dbg_valid}, 32'h0);
        release_reset();

        // Load two full words, last on byte 8.
        send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0);
        check("load1_not_done", {31'h0, load_done}, 32'h0);
        check("load1_rdata_zero", mem_rdata, 32'h0);
        send_byte(8'h00, 1'b1);
        check("load1_done", {31'h0, load_done}, 32'h1);
        check("load1_core_hold", {31'h0, core_hold}, 32'h0);
        check("load1_ready", {31'h0, load_ready}, 32'h0);

        rd(32'h0);
        check("rd_word0", mem_rdata, 32'h0010_0013);
        @(negedge clk);
        mem_addr = 32'h4;
        check("rd_latency_pre", mem_rdata, 32'h0010_0013);
        @(posedge clk);
        #1;
        check("rd_word1", mem_rdata, 32'h0050_0093);
        rd(32'h0000_2000);
        check("rd_out_of_range", mem_rdata, 32'h0);

        // Out-of-range write must not alias onto RAM[0].
        wr(32'h0000_1000, 32'hDEAD_BEEF);
        rd(32'h0);
        check("oor_write_ignored", mem_rdata, 32'h0010_0013);

        wr(MMIO, 32'hCAFE_0001);
        check("mmio_dbg_data", dbg_data, 32'hCAFE_0001);
        check("mmio_dbg_valid_hi", {31'h0, dbg_valid}, 32'h1);
        rd(MMIO);
        check("mmio_dbg_valid_lo", {31'h0, dbg_valid}, 32'h0);
        check("mmio_readback", mem_rdata, 32'hCAFE_0001);

        wr(32'h8, 32'h0);
        wr(32'h8, 32'h1234_5678);
        check("rw_same_cycle_old", mem_rdata, 32'h0);
        rd(32'h8);
        check("rw_new_value", mem_rdata, 32'h1234_5678);

        // Asynchronous reset in RUN.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("runrst_core_hold", {31'h0, core_hold}, 32'h1);
        check("runrst_dbg_data", dbg_data, 32'h0);
        check("runrst_rdata", mem_rdata, 32'h0);
        check("runrst_load_done", {31'h0, load_done}, 32'h0);
        release_reset();

        // Partial final word, last on byte 5.
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
        send_byte(8'h11, 1'b1);
        check("load2_done", {31'h0, load_done}, 32'h1);
        rd(32'h0);
        check("load2_word0", mem_rdata, 32'hDDCC_BBAA);
        rd(32'h4);
        check("load2_word1", mem_rdata, 32'h0000_0011);

        // Reset after 6 bytes, then reload one word.
        reset = 1'b1;
        release_reset();
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b0); send_byte(8'h06, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("loadrst_core_hold", {31'h0, core_hold}, 32'h1);
        check("loadrst_done", {31'h0, load_done}, 32'h0);
        release_reset();
        send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0); send_byte(8'h40, 1'b1);
        check("reload_done", {31'h0, load_done}, 32'h1);
        rd(32'h0);
        check("reload_word0", mem_rdata, 32'h4030_2010);
        rd(32'h4);
        check("reload_word1_kept", mem_rdata, 32'h0000_0011);

        // Fill the whole RAM without load_last; the final word ends the load.
        reset = 1'b1;
        release_reset();
        for (int i = 0; i < 4096; i++) begin
            send_byte(8'(i), 1'b0);
            if (i == 4094) begin
                check("full_not_done", {31'h0, load_done}, 32'h0);
            end
        end
        check("full_done", {31'h0, load_done}, 32'h1);
        check("full_ready", {31'h0, load_ready}, 32'h0);
        send_byte(8'hEE, 1'b0);
        rd(32'h0);
        check("full_word0", mem_rdata, 32'h0302_0100);
        rd(32'h0000_0FFC);
        check("full_word_last", mem_rdata, 32'hFFFE_FDFC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
